uart_memory_loader: RTL



---
 rtl/uart_memory_loader_if.sv | 39 +++
 rtl/uart_memory_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_memory_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_memory_loader_if
//  Purpose  : Memory write port and status signals driven by the UART memory
//             loader toward the 16 x 8-bit configuration memory.
//  Signals  : o_W_En    - one-cycle write strobe
//             o_W_Addr  - 4-bit write address, valid with o_W_En
//             o_W_Data  - 8-bit write data, valid with o_W_En
//             o_Err     - one-cycle error pulse (framing / bad command)
//             o_Busy    - packet or byte reception in progress
//  Modports : master - the loader (drives everything)
//             slave  - the memory / observer side
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_memory_loader_if;
    logic       o_W_En;
    logic [3:0] o_W_Addr;
    logic [7:0] o_W_Data;
    logic       o_Err;
    logic       o_Busy;

    modport master (
        output o_W_En,
        output o_W_Addr,
        output o_W_Data,
        output o_Err,
        output o_Busy
    );

    modport slave (
        input  o_W_En,
        input  o_W_Addr,
        input  o_W_Data,
        input  o_Err,
        input  o_Busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_memory_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_memory_loader
//  Purpose  : Receives 8N1 UART bytes and turns {address, data} byte pairs
//             into single-cycle writes on the configuration memory port.
//             An address byte carries CMD_NIBBLE in its upper nibble and the
//             target address in its lower nibble; the next byte is the data.
//  Ports    : i_Clk     - system clock, rising edge
//             i_Rst_L   - synchronous active-low reset
//             i_UART_RX - asynchronous serial input, idle high
//             mem       - memory write port / status (master modport)
//  Params   : CLKS_PER_BIT - clock cycles per UART bit (4..1023)
//             CMD_NIBBLE   - required upper nibble of an address byte
//  Revision : 1.0 - initial release
// ============================================================================
module uart_memory_loader #(
    parameter int         CLKS_PER_BIT = 217,
    parameter logic [3:0] CMD_NIBBLE   = 4'hA
) (
    input  wire logic            i_Clk,
    input  wire logic            i_Rst_L,
    input  wire logic            i_UART_RX,
    uart_memory_loader_if.master mem
);

    // Terminal counts are inclusive of zero, hence the -1.
    localparam logic [9:0] c_BIT_LAST  = 10'(CLKS_PER_BIT - 1);
    localparam logic [9:0] c_HALF_LAST = 10'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_DONE  = 3'd4
    } rx_state_t;

    typedef enum logic [0:0] {
        PK_WAIT_ADDR = 1'b0,
        PK_WAIT_DATA = 1'b1
    } pk_state_t;

    // ------------------------------------------------------------------
    // Input synchroniser (idle-high line, so both stages reset to 1)
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_UART_RX;
            r_rx_sync <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Byte receiver
    // ------------------------------------------------------------------
    rx_state_t  r_rx_state, w_rx_next;
    logic [9:0] r_cnt,      w_cnt_next;
    logic [2:0] r_bit_idx,  w_bit_next;
    logic [7:0] r_shift,    w_shift_next;
    logic       r_stop_ok,  w_stop_ok_next;
    logic       w_byte_valid;
    logic       w_frame_err;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_rx_state <= RX_IDLE;
            r_cnt      <= 10'd0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_stop_ok  <= 1'b0;
        end else begin
            r_rx_state <= w_rx_next;
            r_cnt      <= w_cnt_next;
            r_bit_idx  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_stop_ok  <= w_stop_ok_next;
        end
    end

    always_comb begin
        w_rx_next      = r_rx_state;
        w_cnt_next     = r_cnt;
        w_bit_next     = r_bit_idx;
        w_shift_next   = r_shift;
        w_stop_ok_next = r_stop_ok;

        unique case (r_rx_state)
            RX_IDLE: begin
                w_cnt_next = 10'd0;
                w_bit_next = 3'd0;
                if (!r_rx_sync) begin
                    w_rx_next = RX_START;
                end
            end

            // Wait half a bit, then confirm the start bit is still low so
            // that later samples land near the middle of each bit.
            RX_START: begin
                if (r_cnt == c_HALF_LAST) begin
                    w_cnt_next = 10'd0;
                    w_rx_next  = r_rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    w_cnt_next = r_cnt + 10'd1;
                end
            end

            // LSB first: new bits enter at the top and shift down.
            RX_DATA: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_next   = 10'd0;
                    w_shift_next = {r_rx_sync, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_bit_next = 3'd0;
                        w_rx_next  = RX_STOP;
                    end else begin
                        w_bit_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 10'd1;
                end
            end

            RX_STOP: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_next     = 10'd0;
                    w_stop_ok_next = r_rx_sync;
                    w_rx_next      = RX_DONE;
                end else begin
                    w_cnt_next = r_cnt + 10'd1;
                end
            end

            // Single cycle; short enough that a start bit following the
            // stop bit with no idle time is still caught from IDLE.
            RX_DONE: begin
                w_rx_next = RX_IDLE;
            end

            default: begin
                w_rx_next = RX_IDLE;
            end
        endcase
    end

    assign w_byte_valid = (r_rx_state == RX_DONE) &&  r_stop_ok;
    assign w_frame_err  = (r_rx_state == RX_DONE) && !r_stop_ok;

    // ------------------------------------------------------------------
    // Packet assembler
    // ------------------------------------------------------------------
    pk_state_t  r_pk_state,   w_pk_next;
    logic [3:0] r_addr_latch, w_addr_latch_next;
    logic       r_w_en,       w_w_en_next;
    logic       r_err,        w_err_next;
    logic [3:0] r_w_addr,     w_w_addr_next;
    logic [7:0] r_w_data,     w_w_data_next;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_pk_state   <= PK_WAIT_ADDR;
            r_addr_latch <= 4'd0;
            r_w_en       <= 1'b0;
            r_err        <= 1'b0;
            r_w_addr     <= 4'd0;
            r_w_data     <= 8'd0;
        end else begin
            r_pk_state   <= w_pk_next;
            r_addr_latch <= w_addr_latch_next;
            r_w_en       <= w_w_en_next;
            r_err        <= w_err_next;
            r_w_addr     <= w_w_addr_next;
            r_w_data     <= w_w_data_next;
        end
    end

    // The pending address lives in its own latch so the visible write
    // address/data only change when a strobe actually fires.
    always_comb begin
        w_pk_next         = r_pk_state;
        w_addr_latch_next = r_addr_latch;
        w_w_en_next       = 1'b0;
        w_err_next        = 1'b0;
        w_w_addr_next     = r_w_addr;
        w_w_data_next     = r_w_data;

        if (w_frame_err) begin
            // Corrupted byte: drop any half-received packet as well.
            w_err_next = 1'b1;
            w_pk_next  = PK_WAIT_ADDR;
        end else if (w_byte_valid) begin
            unique case (r_pk_state)
                PK_WAIT_ADDR: begin
                    if (r_shift[7:4] == CMD_NIBBLE) begin
                        w_addr_latch_next = r_shift[3:0];
                        w_pk_next         = PK_WAIT_DATA;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
                PK_WAIT_DATA: begin
                    w_w_en_next   = 1'b1;
                    w_w_addr_next = r_addr_latch;
                    w_w_data_next = r_shift;
                    w_pk_next     = PK_WAIT_ADDR;
                end
                default: begin
                    w_pk_next = PK_WAIT_ADDR;
                end
            endcase
        end
    end

    assign mem.o_W_En   = r_w_en;
    assign mem.o_W_Addr = r_w_addr;
    assign mem.o_W_Data = r_w_data;
    assign mem.o_Err    = r_err;
    assign mem.o_Busy   = (r_pk_state == PK_WAIT_DATA) || (r_rx_state != RX_IDLE);

endmodule
`default_nettype wire
